program_loader: RTL and testbench
=================================

# program_loader

Front end of the CPU that loads a program into the instruction cache before execution. It accepts a byte stream from the host while `download_program` is high and packs bytes into 16-bit instructions. It writes those instructions to consecutive icache addresses and holds the pipeline disabled while it does so. After the stream ends it releases the pipeline with a one-cycle start pulse.

## Interface
Parameters:
- ADDR_W, 8, icache address width; capacity is 2^ADDR_W halfwords.
- FLUSH_CYCLES, 4, number of hold cycles after the last write, before release; minimum 1.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- download_program  in  1  level request; high = loading session active
- byte_valid  in  1  host byte strobe
- byte_data  in  8  host byte; the first byte of each pair is the low byte
- byte_ready  out  1  a byte is accepted when byte_valid && byte_ready
- wr_en  out  1  icache write strobe, one cycle per halfword
- wr_addr  out  ADDR_W  icache write index
- wr_data  out  16  instruction halfword, {second byte, first byte}
- cpu_hold  out  1  drives the pipeline global disable (icache/decode)
- cpu_start  out  1  one-cycle pulse in the first released cycle
- load_count  out  ADDR_W+1  halfwords written in the current or last session
- overflow  out  1  sticky; the session exceeded capacity

## Operation
- Reset values: state IDLE, cpu_hold=1, byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_start=0, load_count=0, overflow=0, pending-low-byte flag cleared.
- byte_ready = (state==LOAD) && download_program; combinational from the state register and input.
- States:
  - IDLE: cpu_hold=1. Go to LOAD when download_program=1.
  - LOAD: cpu_hold=1. Clear load_count, overflow and the pending flag on entry.
    - First accepted byte of a pair: latch it as the low byte and set pending.
    - Second accepted byte: write {byte, low} at wr_addr=load_count, increment load_count, clear pending.
    - When download_program=0, go to FLUSH.
  - FLUSH: cpu_hold=1.
    - If pending was set, the first FLUSH cycle writes {8'h00, low}, counts it, and clears pending.
    - The state stays for exactly FLUSH_CYCLES cycles, then goes to RUN.
  - RUN: cpu_hold=0. cpu_start=1 only in the first RUN cycle. When download_program=1, go to LOAD; a new session starts.
- Capacity: once load_count == 2^ADDR_W, later completed pairs are dropped (no wr_en) and overflow is set. byte_ready stays 1 so the host drains. load_count saturates at 2^ADDR_W.
- A pad write in FLUSH under the same full condition is dropped and sets overflow.
- A session with zero bytes is legal: LOAD -> FLUSH -> RUN with load_count=0 and no writes.
- wr_addr and wr_data hold their last values when wr_en=0.

## Timing
- Write latency: a second byte accepted at edge t gives wr_en=1, wr_addr and wr_data valid for the cycle after t (registered). One write per two accepted bytes; at most one write per cycle.
- IDLE or RUN -> LOAD: byte_ready is 1 in the cycle after download_program is first sampled high.
- When download_program and byte_valid are both high in a cycle, the byte is accepted only if byte_ready=1. When download_program drops, byte_ready falls in the same cycle, so a byte offered in that cycle is not accepted.
- Release: cpu_hold falls and cpu_start rises together, FLUSH_CYCLES+1 cycles after download_program is first sampled low in LOAD. The last write, including any pad, completes at least FLUSH_CYCLES-1 cycles before release.
- Re-entry from RUN: cpu_hold=1 in the cycle after download_program is sampled high.
- Reset mid-session: the state returns to IDLE on the next edge. The pending byte is discarded and no partial write is issued. Data already written to the icache is untouched.

## Test plan
- Basic load: 6 bytes 0x11..0x66 back-to-back, then drop download_program.
  - Required: writes (0,0x2211), (1,0x4433), (2,0x6655); load_count=3.
  - Required: cpu_start pulses exactly FLUSH_CYCLES+1 cycles after the drop, with cpu_hold falling in the same cycle.
- Odd byte count: bytes 0xAB, 0xCD, 0xEF, then drop.
  - Required: writes (0,0xCDAB), then (1,0x00EF) in the first FLUSH cycle; load_count=2.
- Overflow with ADDR_W=2: 10 bytes.
  - Required: exactly 4 writes at addresses 0..3; the 5th pair is dropped; overflow=1; load_count=4; byte_ready stays 1 throughout.
- Reload from RUN: after a completed session, raise download_program again.
  - Required: cpu_hold=1 on the next cycle; load_count and overflow clear.
  - Required: a new 2-byte load writes to address 0.
- Reset mid-pair: assert reset for 1 cycle after a single accepted byte.
  - Required: no wr_en occurs, all outputs return to their reset values, and the state is IDLE, then LOAD if download_program is still high.
- Gapped valid and simultaneous drop: random byte_valid gaps, with a byte offered in the cycle download_program falls.
  - Required: that byte is not accepted; the write contents match the accepted bytes only.

Source files
------------

// File: rtl/program_loader_if.sv
// Host byte stream and icache write bus of the program loader.
// A byte transfers on a rising edge where byte_valid && byte_ready; the host may offer or withdraw at will.
interface program_loader_if #(
    parameter int ADDR_W = 8
) ();
    logic              download_program;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic              cpu_hold;
    logic              cpu_start;
    logic [ADDR_W:0]   load_count;
    logic              overflow;

    modport master (
        output download_program, byte_valid, byte_data,
        input  byte_ready, wr_en, wr_addr, wr_data, cpu_hold, cpu_start, load_count, overflow
    );

    modport slave (
        input  download_program, byte_valid, byte_data,
        output byte_ready, wr_en, wr_addr, wr_data, cpu_hold, cpu_start, load_count, overflow
    );
endinterface

// File: rtl/program_loader.sv
// Packs a host byte stream into 16-bit instructions written to the icache while the CPU is held,
// then releases the pipeline with a one-cycle start pulse after a fixed flush window.
module program_loader #(
    parameter int ADDR_W       = 8,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    program_loader_if.slave     bus,
    output logic [1:0]          dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, FLUSH = 2'd2, RUN = 2'd3} state_e;

    localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_q, state_d;
    logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic              pending_q, pending_d;
    logic [7:0]        low_q, low_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]       wr_data_q, wr_data_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              cpu_start_q, cpu_start_d;
    logic [ADDR_W:0]   load_count_q, load_count_d;
    logic              overflow_q, overflow_d;

    logic              byte_ready;
    logic              accept;
    logic              do_write;
    logic [15:0]       write_word;

    assign byte_ready = (state_q == LOAD) && bus.download_program;
    assign accept     = bus.byte_valid && byte_ready;

    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        pending_d    = pending_q;
        low_d        = low_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        load_count_d = load_count_q;
        overflow_d   = overflow_q;
        do_write     = 1'b0;
        write_word   = 16'h0000;

        case (state_q)
            IDLE, RUN: begin
                if (bus.download_program) begin
                    state_d      = LOAD;
                    load_count_d = '0;
                    overflow_d   = 1'b0;
                    pending_d    = 1'b0;
                end
            end
            LOAD: begin
                if (!bus.download_program) begin
                    // A dangling low byte is padded so it lands in the first FLUSH cycle.
                    state_d     = FLUSH;
                    flush_cnt_d = '0;
                    do_write    = pending_q;
                    write_word  = {8'h00, low_q};
                    pending_d   = 1'b0;
                end else if (accept) begin
                    if (!pending_q) begin
                        low_d     = bus.byte_data;
                        pending_d = 1'b1;
                    end else begin
                        do_write   = 1'b1;
                        write_word = {bus.byte_data, low_q};
                        pending_d  = 1'b0;
                    end
                end
            end
            FLUSH: begin
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d = RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A full icache drops the word but keeps counting nothing and flags overflow.
        if (do_write) begin
            if (load_count_q == CAPACITY) begin
                overflow_d = 1'b1;
            end else begin
                wr_en_d      = 1'b1;
                wr_addr_d    = load_count_q[ADDR_W-1:0];
                wr_data_d    = write_word;
                load_count_d = load_count_q + 1'b1;
            end
        end

        cpu_hold_d  = (state_d != RUN);
        cpu_start_d = (state_d == RUN) && (state_q != RUN);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            flush_cnt_q  <= '0;
            pending_q    <= 1'b0;
            low_q        <= 8'h00;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= 16'h0000;
            cpu_hold_q   <= 1'b1;
            cpu_start_q  <= 1'b0;
            load_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_cnt_q  <= flush_cnt_d;
            pending_q    <= pending_d;
            low_q        <= low_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            cpu_hold_q   <= cpu_hold_d;
            cpu_start_q  <= cpu_start_d;
            load_count_q <= load_count_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bus.byte_ready = byte_ready;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.cpu_hold   = cpu_hold_q;
    assign bus.cpu_start  = cpu_start_q;
    assign bus.load_count = load_count_q;
    assign bus.overflow   = overflow_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: two instances (256-word and 4-word icache) share one random byte stream
// and are checked every cycle against a session-level model, plus literal directed expectations.
module tb_program_loader;
    localparam int FC = 4;
    localparam int P_IDLE = 0, P_LOAD = 1, P_FLUSH = 2, P_RUN = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dp = 1'b0;
    logic       bv = 1'b0;
    logic [7:0] bd = 8'h00;
    logic [1:0] dbg_a, dbg_b;

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 0;

    logic [23:0] exp_q0[$], exp_q1[$], log_a[$], log_b[$];

    int         m_phase[2], m_cnt[2], m_age[2], m_cap[2];
    bit         m_ovf[2], m_pend[2], m_first[2];
    logic [7:0] m_low[2];

    program_loader_if #(.ADDR_W(8)) if_a ();
    program_loader_if #(.ADDR_W(2)) if_b ();

    assign if_a.download_program = dp;
    assign if_a.byte_valid       = bv;
    assign if_a.byte_data        = bd;
    assign if_b.download_program = dp;
    assign if_b.byte_valid       = bv;
    assign if_b.byte_data        = bd;

    program_loader #(.ADDR_W(8), .FLUSH_CYCLES(FC)) dut_a (
        .clk(clk), .reset(rst_n), .bus(if_a.slave), .dbg_state(dbg_a)
    );
    program_loader #(.ADDR_W(2), .FLUSH_CYCLES(FC)) dut_b (
        .clk(clk), .reset(rst_n), .bus(if_b.slave), .dbg_state(dbg_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    task automatic m_write(input int k, input logic [15:0] w);
        logic [23:0] e;
        if (m_cnt[k] >= m_cap[k]) begin
            m_ovf[k] = 1'b1;
        end else begin
            e = {8'(m_cnt[k]), w};
            if (k == 0) exp_q0.push_back(e);
            else exp_q1.push_back(e);
            m_cnt[k]++;
        end
    endtask

    task automatic m_new_session(input int k);
        m_phase[k] = P_LOAD;
        m_cnt[k]   = 0;
        m_ovf[k]   = 1'b0;
        m_pend[k]  = 1'b0;
        m_first[k] = 1'b0;
    endtask

    task automatic m_step(input int k);
        if (!rst_n) begin
            m_phase[k] = P_IDLE;
            m_cnt[k]   = 0;
            m_ovf[k]   = 1'b0;
            m_pend[k]  = 1'b0;
            m_first[k] = 1'b0;
            return;
        end
        case (m_phase[k])
            P_IDLE: if (dp) m_new_session(k);
            P_LOAD: begin
                if (!dp) begin
                    if (m_pend[k]) m_write(k, {8'h00, m_low[k]});
                    m_pend[k]  = 1'b0;
                    m_phase[k] = P_FLUSH;
                    m_age[k]   = 0;
                end else if (bv) begin
                    if (!m_pend[k]) begin
                        m_low[k]  = bd;
                        m_pend[k] = 1'b1;
                    end else begin
                        m_write(k, {bd, m_low[k]});
                        m_pend[k] = 1'b0;
                    end
                end
            end
            P_FLUSH: begin
                m_age[k]++;
                if (m_age[k] == FC) begin
                    m_phase[k] = P_RUN;
                    m_first[k] = 1'b1;
                end
            end
            default: begin
                m_first[k] = 1'b0;
                if (dp) m_new_session(k);
            end
        endcase
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) m_step(k);
        started = 1;
    end

    // ---------------- per-cycle compare ----------------
    task automatic cmp(input int k, input logic rdy, input logic hold, input logic start, input logic we,
                       input logic [7:0] addr, input logic [15:0] data, input logic [8:0] cnt, input logic ovf);
        logic [23:0] e;
        bit has;
        string p;
        p = (k == 0) ? "a" : "b";
        has = (k == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
        if (has) begin
            e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk({p, ".wr_en"}, we, 1'b1);
            chk({p, ".wr_addr"}, addr, e[23:16]);
            chk({p, ".wr_data"}, data, e[15:0]);
        end else begin
            chk({p, ".wr_en_idle"}, we, 1'b0);
        end
        chk({p, ".byte_ready"}, rdy, (m_phase[k] == P_LOAD) && dp);
        chk({p, ".cpu_hold"}, hold, m_phase[k] != P_RUN);
        chk({p, ".cpu_start"}, start, m_first[k]);
        chk({p, ".load_count"}, cnt, 9'(m_cnt[k]));
        chk({p, ".overflow"}, ovf, m_ovf[k]);
    endtask

    always @(negedge clk) begin
        if (started) begin
            if (if_a.wr_en) log_a.push_back({if_a.wr_addr, if_a.wr_data});
            if (if_b.wr_en) log_b.push_back({6'b0, if_b.wr_addr, if_b.wr_data});
            cmp(0, if_a.byte_ready, if_a.cpu_hold, if_a.cpu_start, if_a.wr_en, if_a.wr_addr,
                if_a.wr_data, if_a.load_count, if_a.overflow);
            cmp(1, if_b.byte_ready, if_b.cpu_hold, if_b.cpu_start, if_b.wr_en, {6'b0, if_b.wr_addr},
                if_b.wr_data, {6'b0, if_b.load_count}, if_b.overflow);
        end
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        if (gap > 0) begin
            bv = 1'b0;
            repeat (gap) tick();
        end
        bv = 1'b1;
        bd = b;
        n = 0;
        while (!if_a.byte_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("send.ready_timeout", 32'(n), 32'd0);
        tick();
    endtask

    task automatic drop_and_release(input bit offer);
        int n;
        dp = 1'b0;
        bv = offer;
        bd = 8'($urandom);
        tick();
        bv = 1'b0;
        n = 1;
        while (!if_a.cpu_start && n < 20) begin
            tick();
            n++;
        end
        chk("release.delay", 32'(n), 32'(FC + 1));
        chk("release.hold_low", if_a.cpu_hold, 1'b0);
    endtask

    function automatic logic [23:0] log_at(input bit b, input int i);
        if (!b) return (i < log_a.size()) ? log_a[i] : 24'hFFFFFF;
        return (i < log_b.size()) ? log_b[i] : 24'hFFFFFF;
    endfunction

    initial begin
        m_cap = '{256, 4};

        // reset values
        rst_n = 1'b0;
        repeat (3) tick();
        chk("reset.hold", if_a.cpu_hold, 1'b1);
        chk("reset.ready", if_a.byte_ready, 1'b0);
        chk("reset.wr_en", if_a.wr_en, 1'b0);
        chk("reset.wr_addr", if_a.wr_addr, 8'h00);
        chk("reset.wr_data", if_a.wr_data, 16'h0000);
        chk("reset.count", if_a.load_count, 9'd0);
        chk("reset.state", dbg_a, 2'd0);
        rst_n = 1'b1;
        tick();

        // basic six-byte load
        log_a.delete();
        dp = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) send_byte(8'(8'h11 * (i + 1)), 0);
        bv = 1'b0;
        drop_and_release(1'b0);
        chk("basic.nwrites", 32'(log_a.size()), 32'd3);
        chk("basic.w0", log_at(0, 0), {8'h00, 16'h2211});
        chk("basic.w1", log_at(0, 1), {8'h01, 16'h4433});
        chk("basic.w2", log_at(0, 2), {8'h02, 16'h6655});
        chk("basic.count", if_a.load_count, 9'd3);

        // reload from RUN with an odd byte count
        tick();
        log_a.delete();
        dp = 1'b1;
        tick();
        chk("reload.hold", if_a.cpu_hold, 1'b1);
        chk("reload.count", if_a.load_count, 9'd0);
        send_byte(8'hAB, 0);
        send_byte(8'hCD, 0);
        send_byte(8'hEF, 0);
        bv = 1'b0;
        drop_and_release(1'b0);
        chk("odd.nwrites", 32'(log_a.size()), 32'd2);
        chk("odd.w0", log_at(0, 0), {8'h00, 16'hCDAB});
        chk("odd.pad", log_at(0, 1), {8'h01, 16'h00EF});
        chk("odd.count", if_a.load_count, 9'd2);

        // overflow of the 4-word instance
        log_a.delete();
        log_b.delete();
        dp = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) send_byte(8'($urandom), 0);
        bv = 1'b0;
        drop_and_release(1'b0);
        chk("ovf.nwrites", 32'(log_b.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("ovf.addr", 32'(log_at(1, i) >> 16), 32'(i));
        chk("ovf.flag", if_b.overflow, 1'b1);
        chk("ovf.count", if_b.load_count, 3'd4);
        chk("ovf.big_count", if_a.load_count, 9'd5);

        // new two-byte session restarts at address 0 and clears overflow
        log_a.delete();
        dp = 1'b1;
        tick();
        chk("reload.ovf_clear", if_b.overflow, 1'b0);
        send_byte(8'h34, 0);
        send_byte(8'h12, 0);
        bv = 1'b0;
        drop_and_release(1'b0);
        chk("reload.w0", log_at(0, 0), {8'h00, 16'h1234});
        chk("reload.count", if_a.load_count, 9'd1);

        // reset after one accepted byte: the pending byte is discarded
        log_a.delete();
        dp = 1'b1;
        tick();
        send_byte(8'h5A, 0);
        bv = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("rst_mid.state", dbg_a, 2'd0);
        chk("rst_mid.wr_en", if_a.wr_en, 1'b0);
        chk("rst_mid.hold", if_a.cpu_hold, 1'b1);
        chk("rst_mid.ready", if_a.byte_ready, 1'b0);
        chk("rst_mid.wr_data", if_a.wr_data, 16'h0000);
        chk("rst_mid.count", if_a.load_count, 9'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_mid.reload_state", dbg_a, 2'd1);
        send_byte(8'h77, 0);
        bv = 1'b0;
        drop_and_release(1'b0);
        chk("rst_mid.nwrites", 32'(log_a.size()), 32'd1);
        chk("rst_mid.pad", log_at(0, 0), {8'h00, 16'h0077});

        // empty session
        log_a.delete();
        dp = 1'b1;
        tick();
        drop_and_release(1'b0);
        chk("empty.count", if_a.load_count, 9'd0);
        chk("empty.nwrites", 32'(log_a.size()), 32'd0);

        // random sessions with gaps and bytes offered on the drop cycle
        repeat (30) begin
            dp = 1'b1;
            tick();
            repeat ($urandom_range(0, 14)) send_byte(8'($urandom), $urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) bv = 1'b0;
            drop_and_release($urandom_range(0, 1) == 1);
            repeat ($urandom_range(0, 3)) tick();
        end

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
